shared_mem_arbiter: RTL and testbench

//  Arbitrates N core data ports onto one single-port shared data memory (1-cycle sync read).

---
 rtl/shared_mem_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/shared_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_shared_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_mem_pkg.sv
// Shared types and helpers for the shared data-memory arbiter.
package shared_mem_pkg;

    typedef enum logic [0:0] {
        ARB_UNLOCKED = 1'b0,
        ARB_LOCKED   = 1'b1
    } arb_state_e;

    localparam int unsigned MEM_DW = 32;

    // One core's beat at the default data width.
    typedef struct packed {
        logic [MEM_DW-1:0]   addr;
        logic [MEM_DW-1:0]   wdata;
        logic                we;
        logic [MEM_DW/8-1:0] mask;
        logic                lock;
    } mem_req_t;

    // Requester index width.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority picker: first requester at or after ptr_i wins.
module rr_arbiter #(
    parameter int unsigned NUM_CORES = 2,
    parameter int unsigned IDX_W     = 1
) (
    input  logic [NUM_CORES-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [NUM_CORES-1:0] gnt_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 valid_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            cand = IDX_W'((32'(ptr_i) + k) % NUM_CORES);
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter of N core data ports onto one single-port shared memory,
// with an owner lock for AMO sequences guarded by an idle watchdog.
module shared_mem_arbiter
    import shared_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned NUM_CORES    = 2,
    parameter int unsigned LOCK_TIMEOUT = 16
) (
    input  logic                              clk,
    input  logic                              arst,
    input  logic [NUM_CORES-1:0]              req_i,
    input  logic [NUM_CORES-1:0]              lock_i,
    input  logic [NUM_CORES-1:0]              we_i,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]   addr_i,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]   wdata_i,
    input  logic [NUM_CORES*DATA_WIDTH/8-1:0] mask_i,
    output logic [NUM_CORES-1:0]              gnt_o,
    output logic [NUM_CORES-1:0]              rvalid_o,
    output logic [DATA_WIDTH-1:0]             rdata_o,
    output logic                              lock_err_o,
    output logic [DATA_WIDTH-1:0]             mem_addr_o,
    output logic [DATA_WIDTH-1:0]             mem_wdata_o,
    output logic                              mem_we_o,
    output logic [DATA_WIDTH/8-1:0]           mem_mask_o,
    input  logic [DATA_WIDTH-1:0]             mem_rdata_i
);

    localparam int unsigned IDX_W  = idx_width(NUM_CORES);
    localparam int unsigned MASK_W = DATA_WIDTH / 8;
    localparam int unsigned TMO_W  = $clog2(LOCK_TIMEOUT + 1);

    arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic [NUM_CORES-1:0] rvalid_q;

    logic [NUM_CORES-1:0] arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_valid;

    logic [NUM_CORES-1:0] gnt;
    logic [IDX_W-1:0]     gidx;
    logic                 any_gnt;
    logic                 lock_err;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (32'(i) == NUM_CORES - 1) ? '0 : i + 1'b1;
    endfunction

    rr_arbiter #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_rr_arbiter (
        .req_i   (req_i),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Grant select; while locked only the owner can win. Held off during reset.
    always_comb begin
        gnt     = '0;
        gidx    = arb_idx;
        any_gnt = 1'b0;
        if (state_q == ARB_UNLOCKED) begin
            gnt     = arb_gnt;
            any_gnt = arb_valid;
        end else if (req_i[owner_q]) begin
            gnt[owner_q] = 1'b1;
            gidx         = owner_q;
            any_gnt      = 1'b1;
        end
        if (arst) begin
            gnt     = '0;
            any_gnt = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        tmo_cnt_d = tmo_cnt_q;
        lock_err  = 1'b0;
        unique case (state_q)
            ARB_UNLOCKED: begin
                if (any_gnt) begin
                    rr_ptr_d = next_idx(gidx);
                    if (lock_i[gidx]) begin
                        state_d   = ARB_LOCKED;
                        owner_d   = gidx;
                        tmo_cnt_d = '0;
                    end
                end
            end
            ARB_LOCKED: begin
                if (any_gnt) begin
                    tmo_cnt_d = '0;
                    if (!lock_i[owner_q]) begin
                        state_d  = ARB_UNLOCKED;
                        rr_ptr_d = next_idx(owner_q);
                    end
                end else if (tmo_cnt_q == TMO_W'(LOCK_TIMEOUT - 1)) begin
                    // Owner went quiet too long: force the lock open.
                    state_d   = ARB_UNLOCKED;
                    rr_ptr_d  = next_idx(owner_q);
                    tmo_cnt_d = '0;
                    lock_err  = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: state_d = ARB_UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= ARB_UNLOCKED;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            tmo_cnt_q <= '0;
            rvalid_q  <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            tmo_cnt_q <= tmo_cnt_d;
            rvalid_q  <= gnt;
        end
    end

    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_we_o    = 1'b0;
        mem_mask_o  = '0;
        if (any_gnt) begin
            mem_addr_o  = addr_i[gidx*DATA_WIDTH +: DATA_WIDTH];
            mem_wdata_o = wdata_i[gidx*DATA_WIDTH +: DATA_WIDTH];
            mem_we_o    = we_i[gidx];
            mem_mask_o  = mask_i[gidx*MASK_W +: MASK_W];
        end
    end

    assign gnt_o      = gnt;
    assign rvalid_o   = rvalid_q;
    assign rdata_o    = mem_rdata_i;
    assign lock_err_o = lock_err;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter: two cores, 32-bit data, lock timeout of 4.
module tb_shared_mem_arbiter;

    logic        clk;
    logic        arst;
    logic [1:0]  req, lock, we;
    logic [63:0] addr, wdata;
    logic [7:0]  mask;
    logic [1:0]  gnt, rvalid;
    logic [31:0] rdata;
    logic        lock_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [3:0]  mem_mask;

    int n_cmp;
    int n_err;

    shared_mem_arbiter #(
        .DATA_WIDTH   (32),
        .NUM_CORES    (2),
        .LOCK_TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .arst        (arst),
        .req_i       (req),
        .lock_i      (lock),
        .we_i        (we),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .mask_i      (mask),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .lock_err_o  (lock_err),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_we_o    (mem_we),
        .mem_mask_o  (mem_mask),
        .mem_rdata_i (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory stand-in: 1-cycle read returning a tagged copy of the address.
    always_ff @(posedge clk) mem_rdata <= mem_addr ^ 32'hDEAD_0000;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        req = '0; lock = '0; we = '0; addr = '0; wdata = '0; mask = '0;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        idle_inputs();
        #3;
        n_cmp++;
        if (gnt !== 2'b00 || rvalid !== 2'b00 || lock_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctl: gnt=%b rvalid=%b lock_err=%b, want 00 00 0",
                     gnt, rvalid, lock_err);
        end
        n_cmp++;
        if (mem_we !== 1'b0 || mem_mask !== 4'h0 || mem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mem: we=%b mask=%h addr=%h, want 0 0 0",
                     mem_we, mem_mask, mem_addr);
        end
        step();
        arst = 1'b0;
    endtask

    task automatic test_single_read();
        step();
        req = 2'b01; addr[31:0] = 32'h10;
        #1;
        n_cmp++;
        if (gnt !== 2'b01 || mem_addr !== 32'h10 || mem_we !== 1'b0 || rvalid !== 2'b00) begin
            n_err++;
            $display("FAIL read_gnt: gnt=%b addr=%h we=%b rvalid=%b, want 01 00000010 0 00",
                     gnt, mem_addr, mem_we, rvalid);
        end
        step();
        idle_inputs();
        #1;
        n_cmp++;
        if (rvalid !== 2'b01 || rdata !== 32'hDEAD_0010) begin
            n_err++;
            $display("FAIL read_resp: rvalid=%b rdata=%h, want 01 dead0010", rvalid, rdata);
        end
        n_cmp++;
        if (gnt !== 2'b00 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_err++;
            $display("FAIL read_idle: gnt=%b addr=%h wdata=%h, want 00 0 0",
                     gnt, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_masked_write();
        step();
        req = 2'b10; we = 2'b10;
        addr[63:32] = 32'h20; wdata[63:32] = 32'h1234; mask[7:4] = 4'b0011;
        #1;
        n_cmp++;
        if (gnt !== 2'b10 || mem_addr !== 32'h20 || mem_wdata !== 32'h1234 ||
            mem_we !== 1'b1 || mem_mask !== 4'b0011) begin
            n_err++;
            $display("FAIL write_mem: gnt=%b addr=%h wdata=%h we=%b mask=%b, want 10 20 1234 1 0011",
                     gnt, mem_addr, mem_wdata, mem_we, mem_mask);
        end
        step();
        idle_inputs();
        #1;
        n_cmp++;
        if (rvalid !== 2'b10) begin
            n_err++;
            $display("FAIL write_ack: rvalid=%b, want 10", rvalid);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g, prev_g;
        prev_g = 2'b00;
        for (int k = 0; k < 5; k++) begin
            step();
            req = 2'b11;
            addr[31:0] = 32'h100; addr[63:32] = 32'h200;
            #1;
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            n_cmp++;
            if (gnt !== exp_g || mem_addr !== ((k % 2 == 0) ? 32'h100 : 32'h200)) begin
                n_err++;
                $display("FAIL rr_beat%0d: gnt=%b addr=%h, want %b", k, gnt, mem_addr, exp_g);
            end
            n_cmp++;
            if (rvalid !== prev_g) begin
                n_err++;
                $display("FAIL rr_rvalid%0d: rvalid=%b, want %b", k, rvalid, prev_g);
            end
            prev_g = exp_g;
        end
        step();
        idle_inputs();
        #1;
        n_cmp++;
        if (rvalid !== 2'b01 || gnt !== 2'b00) begin
            n_err++;
            $display("FAIL rr_tail: rvalid=%b gnt=%b, want 01 00", rvalid, gnt);
        end
    endtask

    task automatic test_lock_amo();
        step();
        req = 2'b11; lock = 2'b10;
        addr[31:0] = 32'h300; addr[63:32] = 32'h40;
        #1;
        n_cmp++;
        if (gnt !== 2'b10 || mem_we !== 1'b0 || mem_addr !== 32'h40) begin
            n_err++;
            $display("FAIL amo_read: gnt=%b we=%b addr=%h, want 10 0 40", gnt, mem_we, mem_addr);
        end
        // Owner skips a cycle: core0 must still stall.
        step();
        req = 2'b01; lock = 2'b00;
        #1;
        n_cmp++;
        if (gnt !== 2'b00 || rvalid !== 2'b10) begin
            n_err++;
            $display("FAIL amo_stall: gnt=%b rvalid=%b, want 00 10", gnt, rvalid);
        end
        step();
        req = 2'b11; we = 2'b10; wdata[63:32] = 32'hA5; mask[7:4] = 4'b1111;
        #1;
        n_cmp++;
        if (gnt !== 2'b10 || mem_we !== 1'b1 || mem_wdata !== 32'hA5 || mem_mask !== 4'hF) begin
            n_err++;
            $display("FAIL amo_write: gnt=%b we=%b wdata=%h mask=%h, want 10 1 a5 f",
                     gnt, mem_we, mem_wdata, mem_mask);
        end
        step();
        req = 2'b01; we = 2'b00;
        #1;
        n_cmp++;
        if (gnt !== 2'b01 || mem_addr !== 32'h300 || rvalid !== 2'b10) begin
            n_err++;
            $display("FAIL amo_release: gnt=%b addr=%h rvalid=%b, want 01 300 10",
                     gnt, mem_addr, rvalid);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_lock_timeout();
        step();
        req = 2'b01; lock = 2'b01;
        #1;
        n_cmp++;
        if (gnt !== 2'b01) begin
            n_err++;
            $display("FAIL tmo_lock: gnt=%b, want 01", gnt);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            req = 2'b10; lock = 2'b00;
            #1;
            n_cmp++;
            if (gnt !== 2'b00 || lock_err !== (k == 3)) begin
                n_err++;
                $display("FAIL tmo_idle%0d: gnt=%b lock_err=%b, want 00 %0d",
                         k, gnt, lock_err, (k == 3));
            end
        end
        step();
        #1;
        n_cmp++;
        if (gnt !== 2'b10 || lock_err !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_after: gnt=%b lock_err=%b, want 10 0", gnt, lock_err);
        end
        step();
        #1;
        n_cmp++;
        if (gnt !== 2'b10) begin
            n_err++;
            $display("FAIL tmo_unowned: gnt=%b, want 10", gnt);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_reset_mid_lock();
        step();
        req = 2'b10; lock = 2'b10; we = 2'b10; mask[7:4] = 4'hF; addr[63:32] = 32'h80;
        #1;
        n_cmp++;
        if (gnt !== 2'b10) begin
            n_err++;
            $display("FAIL rst_lock: gnt=%b, want 10", gnt);
        end
        step();
        req = 2'b11;
        arst = 1'b1;
        #1;
        n_cmp++;
        if (gnt !== 2'b00 || rvalid !== 2'b00 || lock_err !== 1'b0 ||
            mem_we !== 1'b0 || mem_mask !== 4'h0 || mem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL rst_async: gnt=%b rvalid=%b err=%b we=%b mask=%h addr=%h, want all 0",
                     gnt, rvalid, lock_err, mem_we, mem_mask, mem_addr);
        end
        step();
        arst = 1'b0; lock = 2'b00; we = 2'b00;
        #1;
        n_cmp++;
        if (gnt !== 2'b01) begin
            n_err++;
            $display("FAIL rst_after: gnt=%b, want 01", gnt);
        end
        step();
        idle_inputs();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single_read();
        test_masked_write();
        test_round_robin();
        test_lock_amo();
        test_lock_timeout();
        test_reset_mid_lock();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
